// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: HC-SR04 trigger/echo timer producing a millimetre distance sample per cycle.
module ultrasonic_ranger #(
    parameter int CLK_PER_US   = 50,
    parameter int TRIG_US      = 10,
    parameter int PERIOD_US    = 60000,
    parameter int ECHO_WAIT_US = 30000,
    parameter int MAX_ECHO_US  = 25000,
    parameter int OBST_MM      = 40
) (
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        UV_echo,
    output logic        UV_trig,
    output logic [15:0] distance_mm,
    output logic        dist_valid,
    output logic        echo_timeout,
    output logic        obstacle,
    output logic        busy
);
    localparam int PW = $clog2(CLK_PER_US);
    localparam int SW = $clog2(ECHO_WAIT_US + 1);
    localparam int EW = $clog2(MAX_ECHO_US + 1);
    localparam int NW = $clog2(PERIOD_US + 1);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, DONE, HOLDOFF} state_t;
    state_t state, state_nx;

    logic e1, e2, e3, rise, fall;
    logic [PW-1:0] pre, ppre;
    logic [SW-1:0] st_us;
    logic [EW-1:0] echo_us;
    logic [NW-1:0] per_us;
    logic got_echo, tick, ptick, entry, enter_trig, per_done, timed_out;
    logic [19:0] prod;
    logic [15:0] dist_c;

    assign rise       = e2 & ~e3;
    assign fall       = ~e2 & e3;
    assign tick       = pre == PW'(CLK_PER_US - 1);
    assign ptick      = ppre == PW'(CLK_PER_US - 1);
    assign entry      = state_nx != state;
    assign enter_trig = state_nx == TRIG && state != TRIG;
    // The period runs on its own prescaler so per-state realignment never stretches it.
    assign per_done   = per_us == NW'(PERIOD_US) || (ptick && per_us == NW'(PERIOD_US - 1));
    assign timed_out  = !got_echo || echo_us == EW'(MAX_ECHO_US);
    assign prod       = 20'(echo_us) * 20'd11;
    assign dist_c     = (prod >> 6) > 20'h0FFFE ? 16'hFFFE : 16'(prod >> 6);
    assign UV_trig    = state == TRIG;
    assign busy       = state != IDLE;

    always_ff @(posedge clk_50M or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      state_nx = enable ? TRIG : IDLE;
            TRIG:      state_nx = (tick && st_us == SW'(TRIG_US - 1)) ? WAIT_ECHO : TRIG;
            WAIT_ECHO: state_nx = rise ? MEASURE
                                : (tick && st_us == SW'(ECHO_WAIT_US - 1)) ? DONE : WAIT_ECHO;
            MEASURE:   state_nx = (fall || echo_us == EW'(MAX_ECHO_US)) ? DONE : MEASURE;
            DONE:      state_nx = HOLDOFF;
            HOLDOFF:   state_nx = per_done ? (enable ? TRIG : IDLE) : HOLDOFF;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst_n)
        if (!rst_n) begin
            {e1, e2, e3} <= '0;
            pre          <= '0;
            ppre         <= '0;
            st_us        <= '0;
            echo_us      <= '0;
            per_us       <= '0;
            got_echo     <= 1'b0;
            distance_mm  <= 16'hFFFF;
            dist_valid   <= 1'b0;
            echo_timeout <= 1'b0;
            obstacle     <= 1'b0;
        end else begin
            {e1, e2, e3} <= {UV_echo, e1, e2};
            pre          <= (entry || tick) ? '0 : pre + PW'(1);
            ppre         <= (enter_trig || ptick) ? '0 : ppre + PW'(1);
            st_us        <= entry ? '0 : (tick && (state == TRIG || state == WAIT_ECHO)) ? st_us + SW'(1) : st_us;
            echo_us      <= (state_nx == MEASURE && entry) ? '0 : (state == MEASURE && tick) ? echo_us + EW'(1) : echo_us;
            per_us       <= enter_trig ? '0 : (ptick && per_us != NW'(PERIOD_US)) ? per_us + NW'(1) : per_us;
            got_echo     <= enter_trig ? 1'b0 : (state_nx == MEASURE) ? 1'b1 : got_echo;
            dist_valid   <= state == DONE;
            if (state == DONE) begin
                distance_mm  <= timed_out ? 16'hFFFF : dist_c;
                echo_timeout <= timed_out;
                obstacle     <= !timed_out && dist_c < 16'(OBST_MM);
            end
        end
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb_ultrasonic_ranger: scoreboard bench for ultrasonic_ranger using shortened timing parameters.
module tb_ultrasonic_ranger;
    localparam int CPU  = 4;
    localparam int TRIG = 10;
    localparam int PER  = 1500;
    localparam int EWT  = 600;
    localparam int MAXE = 500;
    localparam int OBST = 40;

    logic clk_50M = 1'b0, rst_n = 1'b0, enable = 1'b0, UV_echo = 1'b0;
    logic UV_trig, dist_valid, echo_timeout, obstacle, busy;
    logic [15:0] distance_mm;
    int n_chk = 0, n_fail = 0, cyc = 0;

    typedef struct packed {logic [15:0] d; logic t; logic o;} exp_t;
    exp_t q[$];

    ultrasonic_ranger #(
        .CLK_PER_US(CPU), .TRIG_US(TRIG), .PERIOD_US(PER),
        .ECHO_WAIT_US(EWT), .MAX_ECHO_US(MAXE), .OBST_MM(OBST)
    ) dut (
        .clk_50M(clk_50M), .rst_n(rst_n), .enable(enable), .UV_echo(UV_echo),
        .UV_trig(UV_trig), .distance_mm(distance_mm), .dist_valid(dist_valid),
        .echo_timeout(echo_timeout), .obstacle(obstacle), .busy(busy)
    );

    always #5 clk_50M = ~clk_50M;
    always @(posedge clk_50M) cyc++;

    always @(negedge clk_50M) begin
        if (dist_valid === 1'b1) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: dist=%0d to=%b obs=%b with nothing expected", distance_mm, echo_timeout, obstacle);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({distance_mm, echo_timeout, obstacle} !== {e.d, e.t, e.o}) begin
                    n_fail++;
                    $display("FAIL sample: got dist=%0d to=%b obs=%b, expected dist=%0d to=%b obs=%b",
                             distance_mm, echo_timeout, obstacle, e.d, e.t, e.o);
                end
            end
        end
    end

    task automatic wait_trig(input logic level, input string tag);
        int k = 0;
        while (UV_trig !== level && k < 20000) begin
            @(negedge clk_50M);
            k++;
        end
        n_chk++;
        if (UV_trig !== level) begin
            n_fail++;
            $display("FAIL %s: UV_trig=%b, wanted %b within 20000 cycles", tag, UV_trig, level);
        end
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (q.size() != 0 && k < 8000) begin
            @(negedge clk_50M);
            k++;
        end
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d samples outstanding, expected 0", tag, q.size());
            q.delete();
        end
    endtask

    task automatic echo_pulse(input int delay_us, input int width_us, input exp_t e, input string tag);
        wait_trig(1'b1, tag);
        wait_trig(1'b0, tag);
        repeat (delay_us * CPU) @(negedge clk_50M);
        q.push_back(e);
        UV_echo = 1'b1;
        repeat (width_us * CPU) @(negedge clk_50M);
        UV_echo = 1'b0;
        drain(tag);
    endtask

    task automatic test_reset;
        int rises = 0;
        repeat (CPU) @(negedge clk_50M);
        n_chk += 6;
        if (UV_trig !== 1'b0)           begin n_fail++; $display("FAIL rst_trig: got %b expected 0", UV_trig); end
        if (distance_mm !== 16'hFFFF)   begin n_fail++; $display("FAIL rst_dist: got %h expected ffff", distance_mm); end
        if (dist_valid !== 1'b0)        begin n_fail++; $display("FAIL rst_valid: got %b expected 0", dist_valid); end
        if (echo_timeout !== 1'b0)      begin n_fail++; $display("FAIL rst_timeout: got %b expected 0", echo_timeout); end
        if (obstacle !== 1'b0)          begin n_fail++; $display("FAIL rst_obstacle: got %b expected 0", obstacle); end
        if (busy !== 1'b0)              begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        repeat (200) begin
            @(negedge clk_50M);
            if (UV_trig === 1'b1) rises++;
        end
        n_chk += 2;
        if (rises != 0)    begin n_fail++; $display("FAIL idle_trig: %0d high cycles, expected 0", rises); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_trigger_timing;
        int h = 0, f = 0, r0, r1;
        @(negedge clk_50M);
        enable = 1'b1;
        q.push_back('{16'hFFFF, 1'b1, 1'b0});
        wait_trig(1'b1, "first_rise");
        r0 = cyc;
        while (UV_trig === 1'b1 && h < 1000) begin
            @(negedge clk_50M);
            h++;
        end
        n_chk++;
        if (h != TRIG * CPU) begin n_fail++; $display("FAIL trig_width: got %0d cycles expected %0d", h, TRIG * CPU); end
        while (dist_valid !== 1'b1 && f < 5000) begin
            @(negedge clk_50M);
            f++;
        end
        n_chk++;
        if (f != EWT * CPU + 1) begin n_fail++; $display("FAIL noecho_latency: got %0d cycles expected %0d", f, EWT * CPU + 1); end
        wait_trig(1'b1, "second_rise");
        r1 = cyc;
        n_chk++;
        if (r1 - r0 != PER * CPU) begin n_fail++; $display("FAIL trig_period: got %0d cycles expected %0d", r1 - r0, PER * CPU); end
        drain("noecho_drain");
    endtask

    task automatic test_echo_widths;
        echo_pulse(200, 100, '{16'd17, 1'b0, 1'b1}, "echo100");
        echo_pulse(200, 200, '{16'd34, 1'b0, 1'b1}, "echo200");
        echo_pulse(200, 300, '{16'd51, 1'b0, 1'b0}, "echo300");
    endtask

    task automatic test_back_to_back;
        echo_pulse(200, MAXE + 50, '{16'hFFFF, 1'b1, 1'b0}, "echo_overlong");
        echo_pulse(200, 100, '{16'd17, 1'b0, 1'b1}, "echo_recover");
    endtask

    task automatic test_enable_low;
        int k = 0, rises = 0;
        wait_trig(1'b1, "en_low_rise");
        @(negedge clk_50M);
        enable = 1'b0;
        echo_pulse(200, 300, '{16'd51, 1'b0, 1'b0}, "en_low_echo");
        while (busy !== 1'b0 && k < 8000) begin
            @(negedge clk_50M);
            k++;
        end
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL en_low_idle: busy=%b expected 0", busy); end
        repeat (500) begin
            @(negedge clk_50M);
            if (UV_trig === 1'b1) rises++;
        end
        n_chk += 2;
        if (rises != 0)            begin n_fail++; $display("FAIL en_low_trig: %0d high cycles expected 0", rises); end
        if (distance_mm !== 16'd51) begin n_fail++; $display("FAIL en_low_hold: dist=%0d expected 51", distance_mm); end
    endtask

    task automatic test_reset_mid_measure;
        @(negedge clk_50M);
        enable = 1'b1;
        wait_trig(1'b1, "rstm_rise");
        wait_trig(1'b0, "rstm_fall");
        repeat (200 * CPU) @(negedge clk_50M);
        UV_echo = 1'b1;
        repeat (50 * CPU) @(negedge clk_50M);
        rst_n = 1'b0;
        #1;
        n_chk += 3;
        if (UV_trig !== 1'b0)         begin n_fail++; $display("FAIL rstm_trig: got %b expected 0", UV_trig); end
        if (busy !== 1'b0)            begin n_fail++; $display("FAIL rstm_busy: got %b expected 0", busy); end
        if (distance_mm !== 16'hFFFF) begin n_fail++; $display("FAIL rstm_dist: got %h expected ffff", distance_mm); end
        enable  = 1'b0;
        UV_echo = 1'b0;
        repeat (10) @(negedge clk_50M);
        rst_n = 1'b1;
        repeat (10) @(negedge clk_50M);
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstm_idle: busy=%b expected 0", busy); end
        enable = 1'b1;
        echo_pulse(200, 200, '{16'd34, 1'b0, 1'b1}, "rstm_fresh");
    endtask

    initial begin
        test_reset();
        test_trigger_timing();
        test_echo_widths();
        test_back_to_back();
        test_enable_low();
        test_reset_mid_measure();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
